// File: rtl/conv_pkg.sv
// Shared pixel/window types and sizing helpers for the conv_window_buffer / conv_layer family.
package conv_pkg;

  localparam int DEF_INPUT_SIZE     = 32;
  localparam int DEF_INPUT_CHANNELS = 3;
  localparam int DEF_KERNEL_SIZE    = 3;
  localparam int DEF_PX_SIZE        = 8;

  typedef logic [DEF_PX_SIZE-1:0] px_t;
  typedef px_t [DEF_INPUT_CHANNELS-1:0] pixel_t;
  typedef pixel_t [DEF_KERNEL_SIZE-1:0][DEF_KERNEL_SIZE-1:0] window_t;

  // Valid output edge for a stride-1, unpadded KxK window.
  function automatic int out_size(input int in_size, input int k);
    return in_size - (k - 1);
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One frame row of pixels in block-RAM style storage with a registered read port.
// The caller presents the read address one accept ahead so data is ready when the pixel arrives.
module conv_line_buffer #(
  parameter  int DEPTH = 32,
  parameter  int WIDTH = 24,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/conv_window_buffer.sv
// Streaming KxK sliding-window generator (stride 1, no padding) over row-major pixel beats.
// Optional CONV_WIN_SYNC_EN adds s_sof, which forces the accepted beat to position (0,0).
module conv_window_buffer
  import conv_pkg::*;
#(
  parameter  int INPUT_SIZE     = DEF_INPUT_SIZE,
  parameter  int INPUT_CHANNELS = DEF_INPUT_CHANNELS,
  parameter  int KERNEL_SIZE    = DEF_KERNEL_SIZE,
  parameter  int PX_SIZE        = DEF_PX_SIZE,
  localparam int OUTPUT_SIZE    = out_size(INPUT_SIZE, KERNEL_SIZE),
  localparam int OW             = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic s_valid,
  output logic s_ready,
  input  logic [INPUT_CHANNELS-1:0][PX_SIZE-1:0] s_px,
`ifdef CONV_WIN_SYNC_EN
  input  logic s_sof,
`endif
  output logic m_valid,
  input  logic m_ready,
  output logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][INPUT_CHANNELS-1:0][PX_SIZE-1:0] m_window,
  output logic [OW-1:0] m_row,
  output logic [OW-1:0] m_col,
  output logic frame_done
);

  localparam int CW = $clog2(INPUT_SIZE);
  localparam int PW = INPUT_CHANNELS * PX_SIZE;
  localparam logic [CW-1:0] LAST  = CW'(INPUT_SIZE - 1);
  localparam logic [CW-1:0] KM1   = CW'(KERNEL_SIZE - 1);
  localparam logic [OW-1:0] OLAST = OW'(OUTPUT_SIZE - 1);

  logic [CW-1:0] row_reg, col_reg;
  logic [CW-1:0] cur_row, cur_col, row_next, col_next;
  logic          accept, emit;
  logic          m_valid_reg;
  logic [OW-1:0] m_row_reg, m_col_reg;

  logic [KERNEL_SIZE-1:0][PW-1:0]                  column;
  logic [KERNEL_SIZE-2:0][PW-1:0]                  lb_rd;
  logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][PW-1:0] win_reg;

  assign s_ready = !m_valid_reg || m_ready;
  assign accept  = s_valid && s_ready;

`ifdef CONV_WIN_SYNC_EN
  assign cur_row = s_sof ? '0 : row_reg;
  assign cur_col = s_sof ? '0 : col_reg;
`else
  assign cur_row = row_reg;
  assign cur_col = col_reg;
`endif

  assign emit = accept && (cur_row >= KM1) && (cur_col >= KM1);

  always_comb begin
    row_next = row_reg;
    col_next = col_reg;
    if (accept) begin
      if (cur_col == LAST) begin
        col_next = '0;
        row_next = (cur_row == LAST) ? '0 : cur_row + 1'b1;
      end else begin
        col_next = cur_col + 1'b1;
        row_next = cur_row;
      end
    end
  end

  // Column entering the window: buffered rows oldest-first, then the live pixel.
  // Each buffer is rewritten with the column shifted up by one row.
  assign column[KERNEL_SIZE-1] = s_px;

  generate
    for (genvar gi = 0; gi < KERNEL_SIZE - 1; gi++) begin : g_lb
      assign column[gi] = lb_rd[gi];

      conv_line_buffer #(
        .DEPTH (INPUT_SIZE),
        .WIDTH (PW)
      ) u_lb (
        .clk     (clk),
        .wr_en   (accept),
        .wr_addr (cur_col),
        .wr_data (column[gi+1]),
        .rd_addr (col_next),
        .rd_data (lb_rd[gi])
      );
    end
  endgenerate

  // Window rows shift left on every accept, including row-start flush columns.
  generate
    for (genvar gi = 0; gi < KERNEL_SIZE; gi++) begin : g_win
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          win_reg[gi] <= '0;
        end else if (accept) begin
          for (int kx = 0; kx < KERNEL_SIZE - 1; kx++) begin
            win_reg[gi][kx] <= win_reg[gi][kx+1];
          end
          win_reg[gi][KERNEL_SIZE-1] <= column[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_reg     <= '0;
      col_reg     <= '0;
      m_valid_reg <= 1'b0;
      m_row_reg   <= '0;
      m_col_reg   <= '0;
    end else begin
      row_reg <= row_next;
      col_reg <= col_next;
      if (accept) begin
        m_valid_reg <= emit;
        if (emit) begin
          m_row_reg <= OW'(cur_row - KM1);
          m_col_reg <= OW'(cur_col - KM1);
        end
      end else if (m_ready) begin
        m_valid_reg <= 1'b0;
      end
    end
  end

  assign m_valid    = m_valid_reg;
  assign m_window   = win_reg;
  assign m_row      = m_row_reg;
  assign m_col      = m_col_reg;
  assign frame_done = m_valid_reg && m_ready && (m_row_reg == OLAST) && (m_col_reg == OLAST);

endmodule

// File: tb/tb_conv_window_buffer.sv
// Bench for conv_window_buffer on a 5x5 single-channel frame with a 3x3 kernel.
// Define CONV_WIN_SYNC_EN for both bench and RTL to exercise the s_sof resync case.
module tb_conv_window_buffer;

  localparam int N  = 5;
  localparam int K  = 3;
  localparam int C  = 1;
  localparam int PX = 8;
  localparam int O  = N - (K - 1);
  localparam int OW = 2;

  typedef logic [K-1:0][K-1:0][C-1:0][PX-1:0] win_t;

  typedef struct {
    int px_idx;   // accept index after which the window must appear
    int r;
    int c;
    int tl;       // top-left pixel value of expected window
    int fd;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s_valid = 1'b0;
  logic s_ready;
  logic [C-1:0][PX-1:0] s_px = '0;
  logic s_sof = 1'b0;
  logic m_valid;
  logic m_ready;
  win_t m_window;
  logic [OW-1:0] m_row, m_col;
  logic frame_done;

  logic m_ready_cmd = 1'b1;
  logic rnd_ready   = 1'b0;
  logic rnd_bit     = 1'b1;
  assign m_ready = rnd_ready ? rnd_bit : m_ready_cmd;

  int total = 0;
  int bad   = 0;

  win_t got_w[$];
  int   got_r[$];
  int   got_c[$];
  int   got_fd[$];
  int   fd_cnt = 0;
  int   got_base = 0;

  win_t exp_w[$];
  int   exp_r[$];
  int   exp_c[$];
  int   frame_v[N*N];

  vec_t tbl[O*O];

  conv_window_buffer #(
    .INPUT_SIZE     (N),
    .INPUT_CHANNELS (C),
    .KERNEL_SIZE    (K),
    .PX_SIZE        (PX)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_px       (s_px),
`ifdef CONV_WIN_SYNC_EN
    .s_sof      (s_sof),
`endif
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_window   (m_window),
    .m_row      (m_row),
    .m_col      (m_col),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  // Record every handshaked window.
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      got_w.push_back(m_window);
      got_r.push_back(int'(m_row));
      got_c.push_back(int'(m_col));
      got_fd.push_back(int'(frame_done));
    end
    if (rst_n && frame_done) fd_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk_i(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic chk_w(input string name, input win_t got, input win_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic win_t tbl_win(input int tl);
    win_t w;
    for (int ky = 0; ky < K; ky++)
      for (int kx = 0; kx < K; kx++)
        w[ky][kx][0] = PX'(tl + N*ky + kx);
    return w;
  endfunction

  // Reference: every stride-1 KxK window of the frame in raster order.
  task automatic add_exp();
    win_t w;
    for (int r = 0; r < O; r++)
      for (int c = 0; c < O; c++) begin
        for (int ky = 0; ky < K; ky++)
          for (int kx = 0; kx < K; kx++)
            w[ky][kx][0] = PX'(frame_v[(r+ky)*N + c + kx]);
        exp_w.push_back(w);
        exp_r.push_back(r);
        exp_c.push_back(c);
      end
  endtask

  task automatic push(input int v, input bit sof);
    int n = 0;
    s_valid = 1'b1;
    s_px    = PX'(v);
    s_sof   = sof;
    @(negedge clk);
    while (!s_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!s_ready) chk_i("accept_timeout", int'(s_ready), 1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_sof   = 1'b0;
  endtask

  task automatic send_frame(input int base, input bit rnd, input bit gaps);
    for (int i = 0; i < N*N; i++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        @(posedge clk);
        #1;
      end
      frame_v[i] = rnd ? int'($urandom_range(0, 255)) : base + i;
      push(frame_v[i], 1'b0);
    end
    add_exp();
  endtask

  task automatic do_reset();
    s_valid = 1'b0;
    m_ready_cmd = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_i("rst_m_valid", int'(m_valid), 0);
    chk_w("rst_m_window", m_window, '0);
    chk_i("rst_m_row", int'(m_row), 0);
    chk_i("rst_m_col", int'(m_col), 0);
    chk_i("rst_frame_done", int'(frame_done), 0);
    chk_i("rst_s_ready", int'(s_ready), 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    got_base = got_w.size();
    exp_w.delete();
    exp_r.delete();
    exp_c.delete();
  endtask

  task automatic drain_and_compare(input string tag);
    int n = 0;
    while (got_w.size() - got_base < exp_w.size() && n < 400) begin
      n++;
      @(posedge clk);
    end
    repeat (4) @(posedge clk);
    #1;
    chk_i({tag, "_count"}, got_w.size() - got_base, exp_w.size());
    for (int i = 0; i < exp_w.size() && got_base + i < got_w.size(); i++) begin
      $display("%s win %0d r=%0d c=%0d fd=%0d", tag, i, got_r[got_base+i], got_c[got_base+i], got_fd[got_base+i]);
      chk_w({tag, "_window"}, got_w[got_base+i], exp_w[i]);
      chk_i({tag, "_row"}, got_r[got_base+i], exp_r[i]);
      chk_i({tag, "_col"}, got_c[got_base+i], exp_c[i]);
      chk_i({tag, "_fd"}, got_fd[got_base+i], int'(exp_r[i] == O-1 && exp_c[i] == O-1));
    end
    got_base = got_w.size();
    exp_w.delete();
    exp_r.delete();
    exp_c.delete();
  endtask

  // Stream a 5*row+col frame and check each window the cycle after its pixel.
  task automatic run_table(input string tag);
    int p = 0;
    for (int t = 0; t < O*O; t++) begin
      while (p <= tbl[t].px_idx) begin
        push(p, 1'b0);
        if (p != tbl[t].px_idx) chk_i({tag, "_gate_valid"}, int'(m_valid), 0);
        p++;
      end
      $display("%s vec %0d px=%0d r=%0d c=%0d", tag, t, tbl[t].px_idx, tbl[t].r, tbl[t].c);
      chk_i({tag, "_valid"}, int'(m_valid), 1);
      chk_i({tag, "_row"}, int'(m_row), tbl[t].r);
      chk_i({tag, "_col"}, int'(m_col), tbl[t].c);
      chk_w({tag, "_window"}, m_window, tbl_win(tbl[t].tl));
      chk_i({tag, "_fd"}, int'(frame_done), tbl[t].fd);
    end
  endtask

  initial begin
    int fd_base;

    tbl[0] = '{12, 0, 0,  0, 0};
    tbl[1] = '{13, 0, 1,  1, 0};
    tbl[2] = '{14, 0, 2,  2, 0};
    tbl[3] = '{17, 1, 0,  5, 0};
    tbl[4] = '{18, 1, 1,  6, 0};
    tbl[5] = '{19, 1, 2,  7, 0};
    tbl[6] = '{22, 2, 0, 10, 0};
    tbl[7] = '{23, 2, 1, 11, 0};
    tbl[8] = '{24, 2, 2, 12, 1};

    // Single frame, consumer always ready.
    do_reset();
    fd_base = fd_cnt;
    run_table("s1");
    @(posedge clk);
    #1;
    chk_i("s1_fd_count", fd_cnt - fd_base, 1);

    // Consumer stalls on window (1,1).
    do_reset();
    for (int i = 0; i < N*N; i++) frame_v[i] = i;
    add_exp();
    for (int i = 0; i <= 18; i++) push(i, 1'b0);
    m_ready_cmd = 1'b0;
    s_valid = 1'b1;
    s_px = PX'(19);
    repeat (4) begin
      @(negedge clk);
      chk_i("s2_s_ready", int'(s_ready), 0);
      chk_i("s2_valid", int'(m_valid), 1);
      chk_w("s2_hold_window", m_window, tbl_win(6));
      chk_i("s2_hold_row", int'(m_row), 1);
      chk_i("s2_hold_col", int'(m_col), 1);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    m_ready_cmd = 1'b1;
    for (int i = 19; i < N*N; i++) push(i, 1'b0);
    drain_and_compare("s2");

    // Two frames back to back.
    do_reset();
    fd_base = fd_cnt;
    send_frame(0, 1'b0, 1'b0);
    send_frame(100, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    if (got_w.size() >= got_base + 10)
      chk_w("s3_f2_first", got_w[got_base+9], tbl_win(100));
    else
      chk_i("s3_f2_present", got_w.size() - got_base, 10);
    chk_i("s3_fd_count", fd_cnt - fd_base, 2);
    drain_and_compare("s3");

    // Reset mid-frame, then a clean frame.
    do_reset();
    for (int i = 0; i <= 17; i++) push(i, 1'b0);
    chk_i("s4_pre_valid", int'(m_valid), 1);
    rst_n = 1'b0;
    #1;
    chk_i("s4_rst_valid", int'(m_valid), 0);
    chk_w("s4_rst_window", m_window, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_table("s4");

    // Random gaps and random backpressure.
    do_reset();
    rnd_ready = 1'b1;
    send_frame(0, 1'b1, 1'b1);
    send_frame(0, 1'b1, 1'b1);
    send_frame(0, 1'b1, 1'b1);
    drain_and_compare("s5");
    rnd_ready = 1'b0;

`ifdef CONV_WIN_SYNC_EN
    // Start of frame forced part-way through a frame.
    do_reset();
    for (int i = 0; i < 7; i++) push(i, 1'b0);
    for (int i = 0; i < N*N; i++) frame_v[i] = i;
    add_exp();
    push(0, 1'b1);
    for (int i = 1; i < N*N; i++) push(i, 1'b0);
    drain_and_compare("s6");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
